piso_shifter: RTL and testbench
===============================

# piso_shifter

Parallel-in, serial-out shifter that drives a 1-bit serial line (`o_q`) into the team's serial-in register chains on `i_d`. A word is accepted over a valid/ready handshake and emitted MSB-first at one bit per `i_clk` cycle. Back-to-back words stream with no idle gap. This block is the transmitting end for the shift-register and blocking/non-blocking exercises. It gives their benches a deterministic bit source instead of random `i_d` toggling.

## Interface
- `DWIDTH`, default 8: word width in bits, ≥1.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_data`  in  DWIDTH  parallel word; sampled only on acceptance.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  block can accept a word this cycle.
- `o_q`  out  1  serial data, registered.
- `o_busy`  out  1  a word (or its parity bit) is on `o_q`.
- `o_done`  out  1  single-cycle pulse coincident with the final serial bit of a word.

## Operation
- States: IDLE and SHIFT, plus PARITY when `PISO_PARITY_EN` is defined.
- Acceptance occurs on any rising edge where `i_valid && o_ready`. On acceptance:
  - `i_data` loads into the shift register.
  - The bit counter loads `DWIDTH-1`.
  - The state moves to SHIFT.
- SHIFT:
  - `o_q` equals the current MSB of the shift register.
  - Each cycle the register shifts left by one, filling with 0, and the counter decrements.
  - When the counter reaches 0, the state goes to PARITY if enabled, otherwise to IDLE. If a new word is accepted in that same cycle, the state stays in or re-enters SHIFT with the new word.
- PARITY: `o_q` equals the even-parity bit (XOR of the accepted word). Next state is IDLE, or SHIFT if a new word is accepted.
- IDLE: `o_q`=0, `o_busy`=0.
- `o_ready` = (state==IDLE) OR `o_done`. Acceptance in the last-bit cycle therefore gives gapless streaming.
- `o_done` = 1 in the cycle that presents the final bit: SHIFT with counter==0 when parity is disabled, or PARITY when it is enabled.
- `i_valid` asserted while `o_ready`=0 is ignored. The source must hold `i_valid`/`i_data` until it is accepted.
- Counter width is `$clog2(DWIDTH+1)`. For `DWIDTH`=1, SHIFT lasts exactly one cycle with counter==0.

## Timing
- Reset: on any edge with `i_rst`=1:
  - state becomes IDLE;
  - `o_q`=0, `o_busy`=0, `o_done`=0, `o_ready`=1 from the next cycle;
  - the shift register and counter clear.
- `i_valid` is ignored while `i_rst`=1.
- Reset asserted mid-word aborts the word immediately. No `o_done` pulse is produced for it.
- Latency: a word accepted at edge N presents bit `DWIDTH-1` in cycle N+1 and bit `DWIDTH-1-k` in cycle N+1+k.
  - The last data bit is at N+`DWIDTH`.
  - The parity bit, if enabled, is at N+`DWIDTH`+1.
- Word period is `DWIDTH` cycles, or `DWIDTH`+1 with parity. Sustained throughput is one bit per cycle.
- `o_busy` is high in every cycle that carries a data or parity bit and low otherwise.
- `o_q`, `o_busy` and `o_done` are register outputs. `o_ready` is a combinational decode of registered state.

## Configuration
- `PISO_PARITY_EN` defined:
  - the PARITY state exists;
  - an even-parity bit is appended after the LSB;
  - word period is `DWIDTH`+1;
  - `o_done` is asserted in the parity cycle.
- `PISO_PARITY_EN` undefined:
  - no PARITY state and no parity logic;
  - word period is `DWIDTH`;
  - `o_done` is asserted in the LSB cycle.

## Test plan
- Reset: hold `i_rst`=1 for 3 cycles with `i_valid`=1 → `o_q`=0, `o_busy`=0, `o_done`=0 throughout. `o_ready`=1 after release.
- Single word, `DWIDTH`=8, `i_data`=8'hA5 → `o_q` = 1,0,1,0,0,1,0,1 in cycles N+1..N+8. `o_done` high only at N+8. `o_busy` high N+1..N+8.
- Back-to-back: 8'hA5, then 8'h3C held valid → 8'h3C's MSB (0) appears at N+9 with no gap. `o_done` pulses at N+8 and N+16.
- Valid while busy: present 8'hFF at cycle N+3 with `o_ready`=0, holding `i_valid` → 8'hFF is accepted only at N+8, and the A5 bit stream is undisturbed.
- Reset mid-word: assert `i_rst` at N+4 → `o_q`=0 and `o_busy`=0 from the next cycle. No `o_done` pulse. The next accepted word starts cleanly.
- Parity (`PISO_PARITY_EN`), `i_data`=8'h07 → bits 0,0,0,0,0,1,1,1 then parity 1 at N+9. `o_done` at N+9 only. With `DWIDTH`=1 and `i_data`=1 → `o_q` = 1,1.

Source files
------------

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in, serial-out shifter, MSB first, one bit per cycle.
// A word is taken over a valid/ready handshake. Words can be sent back to back
// with no idle cycle between them.
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit (the XOR
// of the word) after the LSB of each word.
//
// Ports:
//   i_clk    clock; all logic changes on the rising edge
//   i_rst    synchronous active-high reset
//   i_data   parallel word, sampled only when it is accepted
//   i_valid  i_data is valid
//   o_ready  a word can be accepted this cycle (combinational, from registered state)
//   o_q      serial data (registered)
//   o_busy   a data or parity bit is on o_q (registered)
//   o_done   one-cycle pulse with the final serial bit of a word (registered)
module piso_shifter #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_q,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned CW = $clog2(DWIDTH + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              q_q, q_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_c;
`ifdef PISO_PARITY_EN
  logic              par_q, par_d;
`endif

  // Ready in IDLE, or while the final bit is on the line, so the next word follows without a gap.
  assign o_ready  = (state_q == IDLE) || done_q;
  assign accept_c = i_valid && o_ready;

  assign o_q    = q_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

  // Next state, shift register and bit counter.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SHIFT;
          sreg_d  = i_data;
          cnt_d   = CW'(DWIDTH - 1);
`ifdef PISO_PARITY_EN
          par_d   = ^i_data;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (accept_c) begin
            state_d = SHIFT;
            sreg_d  = i_data;
            cnt_d   = CW'(DWIDTH - 1);
`ifdef PISO_PARITY_EN
            par_d   = ^i_data;
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end
        end else begin
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q - CW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (accept_c) begin
          state_d = SHIFT;
          sreg_d  = i_data;
          cnt_d   = CW'(DWIDTH - 1);
          par_d   = ^i_data;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output registers track the state being entered so o_q lines up with that state.
  always_comb begin
    q_d    = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    if (state_d == SHIFT) begin
      q_d = sreg_d[DWIDTH-1];
`ifndef PISO_PARITY_EN
      done_d = (cnt_d == '0);
`endif
    end
`ifdef PISO_PARITY_EN
    if (state_d == PARITY) begin
      q_d    = par_d;
      done_d = 1'b1;
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: the driver pushes the expected bit stream for each
// accepted word into a scoreboard queue; a monitor pops and compares one entry
// on every cycle that carries a bit, and checks idle outputs otherwise.
module tb_piso_shifter;

  localparam int unsigned DW = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          q;
  logic          busy;
  logic          done;

  piso_shifter #(.DWIDTH(DW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (ready),
    .o_q     (q),
    .o_busy  (busy),
    .o_done  (done)
  );

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word yields its bits MSB first, then the parity bit if enabled;
  // the final entry carries the done flag.
  task automatic push_word(input logic [DW-1:0] w);
    exp_t e;
    for (int i = DW - 1; i >= 0; i--) begin
      e.b = w[i];
      e.d = (i == 0) && !PAR;
      sb.push_back(e);
    end
    if (PAR) begin
      e.b = ^w;
      e.d = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("ready", ready, (sb.size() == 0) || sb[0].d);
      chk("busy", busy, sb.size() != 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("q", q, e.b);
        chk("done", done, e.d);
      end else begin
        chk("idle_q", q, 1'b0);
        chk("idle_done", done, 1'b0);
      end
    end
  end

  // Present a word and hold it until accepted (bounded wait).
  task automatic send(input logic [DW-1:0] w);
    bit acc;
    data  = w;
    valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      acc = ready && !rst;
      @(posedge clk);
      if (acc) push_word(w);
      #1;
      if (acc) begin
        valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: word %h never accepted", w);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with i_valid asserted; the scoreboard drops any word in flight.
  task automatic do_reset(input int n);
    rst   = 1'b1;
    valid = 1'b1;
    data  = '1;
    repeat (n) begin
      @(posedge clk);
      sb.delete();
      mon_en = 1'b1;
      #1;
    end
    rst   = 1'b0;
    valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < 64)) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d bits still expected", sb.size());
    end
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    do_reset(3);
    idle(2);

    // Single word.
    send(8'hA5);
    drain();
    idle(2);

    // Back to back, then a word held valid while busy.
    send(8'hA5);
    send(8'h3C);
    send(8'hFF);
    drain();
    idle(1);

    // Reset four cycles into a word, then a clean word.
    send(8'hA5);
    idle(3);
    do_reset(1);
    idle(1);
    send(8'h5A);
    drain();

    // Parity-focused words.
    send(8'h07);
    send(8'h00);
    drain();
    idle(1);

    // Random words with random gaps (mostly back to back).
    for (int i = 0; i < 40; i++) begin
      send(DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    idle(3);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
